// File: rtl/conv_window_sched.sv
// -----------------------------------------------------------------------------
// conv_window_sched
//
// Walks every F x F convolution window of an N x N x K feature map, in order
// column (fastest), row, channel, with stride S. Each window goes to the
// lowest-index multiplier lane that is free. A lane is busy from the window
// it receives until that lane pulses lane_done. After the last window the
// scheduler waits for all lanes to finish, then raises result_ready.
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   en           level: 1 = run job, 0 = abort / idle
//   lane_busy    external occupancy per lane (1 = unavailable)
//   lane_done    one-cycle completion pulse per lane
//   win_valid    one-cycle dispatch strobe
//   win_lane     lane receiving the window
//   win_row      top-left row of the window in the image
//   win_col      top-left column of the window in the image
//   win_ch       channel of the window
//   win_idx      linear window index, 0..TOTAL-1
//   lane_start   one-hot copy of win_lane, qualified by win_valid
//   outstanding  number of lanes dispatched but not yet done
//   busy         job in progress (DISPATCH or DRAIN)
//   result_ready job complete (READY)
// -----------------------------------------------------------------------------
module conv_window_sched #(
   parameter int N     = 32,
   parameter int F     = 3,
   parameter int S     = 1,
   parameter int K     = 3,
   parameter int NMULT = 64,
   // Guarded so an illegal parameter set reaches the elaboration checks
   // below instead of dividing by zero.
   localparam int OUT   = (N >= F && S >= 1) ? (N - F) / S + 1 : 1,
   localparam int TOTAL = OUT * OUT * ((K >= 1) ? K : 1),
   localparam int LW    = (NMULT > 1) ? $clog2(NMULT) : 1,
   localparam int CW    = (N > 1) ? $clog2(N) : 1,
   localparam int KW    = (K > 1) ? $clog2(K) : 1,
   localparam int IW    = $clog2(TOTAL + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [NMULT-1:0] lane_busy,
   input  logic [NMULT-1:0] lane_done,
   output logic             win_valid,
   output logic [LW-1:0]    win_lane,
   output logic [CW-1:0]    win_row,
   output logic [CW-1:0]    win_col,
   output logic [KW-1:0]    win_ch,
   output logic [IW-1:0]    win_idx,
   output logic [NMULT-1:0] lane_start,
   output logic [LW:0]      outstanding,
   output logic             busy,
   output logic             result_ready
);

   // Illegal geometry stops elaboration.
   if (N < F) begin : g_err_nf
      $error("conv_window_sched: N must be >= F");
   end
   if (S < 1) begin : g_err_s
      $error("conv_window_sched: S must be >= 1");
   end
   if (K < 1) begin : g_err_k
      $error("conv_window_sched: K must be >= 1");
   end
   if (NMULT < 1) begin : g_err_nmult
      $error("conv_window_sched: NMULT must be >= 1");
   end

   // Pixel position of the last window along a row or column.
   localparam logic [CW-1:0] LAST_POS = CW'((OUT - 1) * S);
   localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

   typedef enum logic [1:0] {
      IDLE,
      DISPATCH,
      DRAIN,
      READY
   } state_t;

   state_t           state;
   logic [NMULT-1:0] mask;      // lanes holding one of our windows
   logic [CW-1:0]    row_cnt;   // next window top-left row (pixels)
   logic [CW-1:0]    col_cnt;   // next window top-left column (pixels)
   logic [KW-1:0]    ch_cnt;
   logic [IW-1:0]    idx_cnt;

   logic [NMULT-1:0] free;
   logic [NMULT-1:0] sel_onehot;
   logic [NMULT-1:0] done_hit;
   logic [LW-1:0]    sel;
   logic [LW:0]      done_cnt;
   logic             any_free;
   logic             dispatch;
   logic             last_win;

   // Lane selection uses the mask as registered at the start of the cycle, so
   // a lane finishing this cycle only becomes eligible in the next one.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch;
      // a path that leaves one unassigned would infer a latch.
      free     = ~mask & ~lane_busy;
      any_free = 1'b0;
      sel      = '0;
      // Scan downward so the lowest free index is the one left in sel.
      for (int i = NMULT - 1; i >= 0; i--) begin
         if (free[i]) begin
            any_free = 1'b1;
            sel      = LW'(i);
         end
      end
      sel_onehot = any_free ? (NMULT'(1) << sel) : '0;

      // Only completions for lanes we actually occupy count.
      done_hit = lane_done & mask;
      done_cnt = '0;
      for (int i = 0; i < NMULT; i++) begin
         done_cnt = done_cnt + (LW + 1)'(done_hit[i]);
      end

      dispatch = (state == DISPATCH) && en && any_free;
      last_win = (idx_cnt == LAST_IDX);
   end

   // NOTE: all state uses non-blocking assignments, so every register samples
   // the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         mask         <= '0;
         row_cnt      <= '0;
         col_cnt      <= '0;
         ch_cnt       <= '0;
         idx_cnt      <= '0;
         win_valid    <= 1'b0;
         win_lane     <= '0;
         win_row      <= '0;
         win_col      <= '0;
         win_ch       <= '0;
         win_idx      <= '0;
         lane_start   <= '0;
         outstanding  <= '0;
         busy         <= 1'b0;
         result_ready <= 1'b0;
      end else if (!en) begin
         // Abort: forget the job and any lanes still working on it. The window
         // outputs keep their last values.
         state        <= IDLE;
         mask         <= '0;
         row_cnt      <= '0;
         col_cnt      <= '0;
         ch_cnt       <= '0;
         idx_cnt      <= '0;
         win_valid    <= 1'b0;
         lane_start   <= '0;
         outstanding  <= '0;
         busy         <= 1'b0;
         result_ready <= 1'b0;
      end else begin
         win_valid   <= dispatch;
         lane_start  <= dispatch ? sel_onehot : '0;
         mask        <= (mask & ~lane_done) | (dispatch ? sel_onehot : '0);
         outstanding <= outstanding + (LW + 1)'(dispatch) - done_cnt;

         if (dispatch) begin
            win_lane <= sel;
            win_row  <= row_cnt;
            win_col  <= col_cnt;
            win_ch   <= ch_cnt;
            win_idx  <= idx_cnt;
            if (last_win) begin
               // Park the counters at zero instead of stepping past the end.
               row_cnt <= '0;
               col_cnt <= '0;
               ch_cnt  <= '0;
               idx_cnt <= '0;
            end else begin
               idx_cnt <= idx_cnt + 1'b1;
               if (col_cnt == LAST_POS) begin
                  col_cnt <= '0;
                  if (row_cnt == LAST_POS) begin
                     row_cnt <= '0;
                     ch_cnt  <= ch_cnt + 1'b1;
                  end else begin
                     row_cnt <= row_cnt + CW'(S);
                  end
               end else begin
                  col_cnt <= col_cnt + CW'(S);
               end
            end
         end

         case (state)
            IDLE: begin
               state        <= DISPATCH;
               busy         <= 1'b1;
               result_ready <= 1'b0;
            end
            DISPATCH: begin
               if (dispatch && last_win) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (outstanding == '0) begin
                  state        <= READY;
                  busy         <= 1'b0;
                  result_ready <= 1'b1;
               end
            end
            READY: begin
               state <= READY;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
